bin_to_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble) upstream of the
//  4-bit-adder display path. Takes the adder result (sum + carry) and produces one
//  4-bit BCD code per digit, each feeding a BCD-to-7-segment decoder instance.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bin_to_bcd_seq_if.sv | 15 +
 rtl/bcd_add3.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 115 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, reserved display codes and a power-of-ten helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_DASH    = 4'hF;
  localparam logic [3:0]  BCD_BLANK   = 4'hE;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq: start/bin in, busy/done/ovf/bcd out.
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 5,
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, done, ovf, bcd);
  modport slave  (input start, bin, output busy, done, ovf, bcd);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (code 4'hE).
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 5,
  parameter int unsigned DIGITS = 2
) (
  input logic            clk,
  input logic            rst_n,
  bin_to_bcd_seq_if.slave io
);
  localparam int unsigned     BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int unsigned     CNT_W    = $clog2(BIN_W + 1);
  localparam int unsigned     MAX_VAL  = pow10(DIGITS) - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_next_q, ovf_next_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic [BCD_W-1:0]   result;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = (adj << 1) | BCD_W'(shreg_q[BIN_W-1]);

  // Final digits as they will be presented: dash fill wins over blanking.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead   = 1'b1;
    result = shifted;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      if (lead && (result[(DIGITS-1-k)*BCD_DIGIT_W +: BCD_DIGIT_W] == '0))
        result[(DIGITS-1-k)*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
      else
        lead = 1'b0;
    end
`else
    result = shifted;
`endif
    if (ovf_next_q) result = {DIGITS{BCD_DASH}};
  end

  // bcd/ovf are loaded on the edge entering DONE so they are valid alongside done.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          state_d    = ST_SHIFT;
          shreg_d    = io.bin;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_next_d = (32'(io.bin) > MAX_VAL);
        end
      end
      ST_SHIFT: begin
        shreg_d   = shreg_q << 1;
        scratch_d = shifted;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          bcd_d   = result;
          ovf_d   = ovf_next_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign io.busy = (state_q != ST_IDLE);
  assign io.done = (state_q == ST_DONE);
  assign io.ovf  = ovf_q;
  assign io.bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 2-digit and a 1-digit instance share clock/reset.
module tb_bin_to_bcd_seq;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bin_to_bcd_seq_if #(.BIN_W(5), .DIGITS(2)) bus2 ();
  bin_to_bcd_seq_if #(.BIN_W(5), .DIGITS(1)) bus1 ();

  bin_to_bcd_seq #(.BIN_W(5), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .io(bus2));
  bin_to_bcd_seq #(.BIN_W(5), .DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         dig1;
    logic [4:0] bin;
    logic [7:0] exp_plain;
    logic [7:0] exp_blank;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one start pulse; lat is the cycle index (accepting cycle = 0) of done, 0 on timeout.
  task automatic run_conv(input bit on1, input logic [4:0] b, output int lat, output int bsy);
    logic d, bz;
    @(negedge clk);
    if (on1) begin bus1.bin = b; bus1.start = 1'b1; end
    else     begin bus2.bin = b; bus2.start = 1'b1; end
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    lat = 0;
    bsy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      d  = on1 ? bus1.done : bus2.done;
      bz = on1 ? bus1.busy : bus2.busy;
      if (bz) bsy++;
      if (d) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int          lat, bsy, ndone;
    logic [7:0]  exp, act, r1, r2;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 5'd19, 8'h19, 8'h19, 1'b0};
    vecs[1]  = '{1'b0, 5'd31, 8'h31, 8'h31, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  8'h00, 8'hE0, 1'b0};
    vecs[3]  = '{1'b0, 5'd9,  8'h09, 8'hE9, 1'b0};
    vecs[4]  = '{1'b0, 5'd10, 8'h10, 8'h10, 1'b0};
    vecs[5]  = '{1'b0, 5'd1,  8'h01, 8'hE1, 1'b0};
    vecs[6]  = '{1'b1, 5'd15, 8'h0F, 8'h0F, 1'b1};
    vecs[7]  = '{1'b1, 5'd8,  8'h08, 8'h08, 1'b0};
    vecs[8]  = '{1'b1, 5'd9,  8'h09, 8'h09, 1'b0};
    vecs[9]  = '{1'b1, 5'd10, 8'h0F, 8'h0F, 1'b1};
    vecs[10] = '{1'b1, 5'd0,  8'h00, 8'h00, 1'b0};

    rst_n      = 1'b0;
    bus2.start = 1'b0; bus2.bin = '0;
    bus1.start = 1'b0; bus1.bin = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus2.busy), 32'd0);
    check("rst_done", 32'(bus2.done), 32'd0);
    check("rst_ovf",  32'(bus2.ovf),  32'd0);
    check("rst_bcd",  32'(bus2.bcd),  32'h00);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus2.busy || bus2.done || bus1.busy || bus1.done) ndone++;
    end
    check("idle_no_activity", 32'(ndone), 32'd0);

    for (int v = 0; v < 11; v++) begin
      run_conv(vecs[v].dig1, vecs[v].bin, lat, bsy);
      exp = (BLANK && !vecs[v].dig1) ? vecs[v].exp_blank : vecs[v].exp_plain;
      act = vecs[v].dig1 ? {4'h0, bus1.bcd} : bus2.bcd;
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd6);
      check($sformatf("v%0d_busy_cycles", v), 32'(bsy), 32'd6);
      check($sformatf("v%0d_bcd", v), 32'(act), 32'(exp));
      check($sformatf("v%0d_ovf", v), 32'(vecs[v].dig1 ? bus1.ovf : bus2.ovf), 32'(vecs[v].exp_ovf));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), 32'(vecs[v].dig1 ? bus1.done : bus2.done), 32'd0);
      check($sformatf("v%0d_bcd_hold", v), 32'(vecs[v].dig1 ? {4'h0, bus1.bcd} : bus2.bcd), 32'(exp));
    end

    // start held 10 cycles; bin changes while busy must not affect the running conversion
    ndone = 0; r1 = '0; r2 = '0;
    @(negedge clk);
    bus2.bin = 5'd7; bus2.start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1)  bus2.bin = 5'd12;
      if (c == 10) bus2.start = 1'b0;
      if (bus2.done) begin
        ndone++;
        if (ndone == 1) r1 = bus2.bcd;
        else if (ndone == 2) r2 = bus2.bcd;
      end
    end
    check("hold_done_count", 32'(ndone), 32'd2);
    check("hold_first_bcd", 32'(r1), BLANK ? 32'hE7 : 32'h07);
    check("hold_second_bcd", 32'(r2), 32'h12);

    // reset during the third SHIFT cycle
    @(negedge clk);
    bus2.bin = 5'd25; bus2.start = 1'b1;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus2.busy), 32'd0);
    check("midrst_done", 32'(bus2.done), 32'd0);
    check("midrst_bcd",  32'(bus2.bcd),  32'h00);
    check("midrst_ovf",  32'(bus2.ovf),  32'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus2.done) ndone++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus2.done || bus2.busy) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_conv(1'b0, 5'd25, lat, bsy);
    check("restart_latency", 32'(lat), 32'd6);
    check("restart_bcd", 32'(bus2.bcd), 32'h25);
    check("restart_ovf", 32'(bus2.ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
